// File: rtl/sub_bytes_seq.sv
// Iterative AES SubBytes stage. It substitutes BYTES_PER_CYCLE bytes per clock through the
// forward or inverse S-box and moves states over valid/ready handshakes on both sides.
module sub_bytes_seq #(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] sb_in,
  input  logic         sb_inv,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] sb_out,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int K     = 16 / BYTES_PER_CYCLE;
  localparam int W     = 8 * BYTES_PER_CYCLE;
  localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(K - 1);

  if (BYTES_PER_CYCLE != 4 && BYTES_PER_CYCLE != 8 && BYTES_PER_CYCLE != 16) begin : g_bad_cfg
    $error("sub_bytes_seq: BYTES_PER_CYCLE must be 4, 8 or 16");
  end

  // Tables are packed with entry 0 in the most significant byte.
  localparam logic [2047:0] FWD_TAB = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  localparam logic [2047:0] INV_TAB = {
    128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] fwd_sbox(input logic [7:0] x);
    return FWD_TAB[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return INV_TAB[{~x, 3'b000} +: 8];
  endfunction

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg;
  logic [127:0]     work_reg, work_next;
  logic             inv_reg;
  logic             accept;
  logic [W-1:0]     chunk_in, chunk_sub;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        accept   = in_valid;
        if (in_valid) state_next = BUSY;
      end
      BUSY: begin
        if (cnt_reg == LAST) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
        accept    = in_valid & out_ready;
        if (out_ready) state_next = in_valid ? BUSY : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Pick out the chunk addressed by the counter and build the updated work word.
  always_comb begin
    chunk_in  = '0;
    work_next = work_reg;
    for (int c = 0; c < K; c++) begin
      if (c == int'(cnt_reg)) begin
        chunk_in                = work_reg[127 - c*W -: W];
        work_next[127 - c*W -: W] = chunk_sub;
      end
    end
  end

  for (genvar gi = 0; gi < BYTES_PER_CYCLE; gi++) begin : g_sbox
    assign chunk_sub[W-1-gi*8 -: 8] = inv_reg ? inv_sbox(chunk_in[W-1-gi*8 -: 8])
                                              : fwd_sbox(chunk_in[W-1-gi*8 -: 8]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work_reg <= '0;
      cnt_reg  <= '0;
      inv_reg  <= 1'b0;
    end else if (accept) begin
      work_reg <= sb_in;
      inv_reg  <= sb_inv;
      cnt_reg  <= '0;
    end else if (state_reg == BUSY) begin
      work_reg <= work_next;
      cnt_reg  <= (cnt_reg == LAST) ? '0 : cnt_reg + 1'b1;
    end
  end

  assign sb_out = work_reg;

endmodule

// File: tb/tb_sub_bytes_seq.sv
// Bench for sub_bytes_seq: three instances (4, 8 and 16 bytes per cycle) checked against
// an arithmetic GF(2^8) S-box model, plus fixed FIPS-197 vectors.
module tb_sub_bytes_seq;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] sb_in_a   [3];
  logic         sb_inv_a  [3];
  logic         in_valid_a[3];
  logic         in_ready_a[3];
  logic [127:0] sb_out_a  [3];
  logic         out_valid_a[3];
  logic         out_ready_a[3];

  int total = 0;
  int bad   = 0;

  logic [7:0] fwd_t [256];
  logic [7:0] inv_t [256];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    sub_bytes_seq #(.BYTES_PER_CYCLE(4 << gi)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .sb_in    (sb_in_a[gi]),
      .sb_inv   (sb_inv_a[gi]),
      .in_valid (in_valid_a[gi]),
      .in_ready (in_ready_a[gi]),
      .sb_out   (sb_out_a[gi]),
      .out_valid(out_valid_a[gi]),
      .out_ready(out_ready_a[gi])
    );
  end

  function automatic int k_of(input int d);
    return 16 / (4 << d);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [7:0] r = b;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  // Multiplicative inverse (x^254) followed by the FIPS-197 affine map.
  task automatic build_tables();
    logic [7:0] x, y, s;
    for (int v = 0; v < 256; v++) begin
      x = 8'(v);
      y = 8'h01;
      for (int e = 0; e < 254; e++) y = gmul(y, x);
      if (v == 0) y = 8'h00;
      s = y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
      fwd_t[v] = s;
      inv_t[s] = x;
    end
  endtask

  function automatic logic [127:0] ref_sub(input logic [127:0] din, input logic inv);
    logic [127:0] r;
    logic [7:0]   b;
    for (int i = 0; i < 16; i++) begin
      b = din[127 - 8*i -: 8];
      r[127 - 8*i -: 8] = inv ? inv_t[b] : fwd_t[b];
    end
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on instance d: accept, check latency and result, then drain.
  task automatic run_one(input int d, input logic [127:0] din, input logic inv,
                         input logic [127:0] want, input string tag);
    int cyc;
    total++;
    if (in_ready_a[d] !== 1'b1) begin
      bad++;
      $display("FAIL %s_ready dut%0d: in_ready=%b want 1", tag, d, in_ready_a[d]);
    end
    in_valid_a[d] = 1'b1;
    sb_in_a[d]    = din;
    sb_inv_a[d]   = inv;
    tick();
    in_valid_a[d] = 1'b0;
    sb_in_a[d]    = rnd128();
    sb_inv_a[d]   = ~inv;
    cyc = 0;
    while (out_valid_a[d] !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    total++;
    if (cyc != k_of(d)) begin
      bad++;
      $display("FAIL %s_latency dut%0d: got %0d cycles want %0d", tag, d, cyc, k_of(d));
    end
    total++;
    if (sb_out_a[d] !== want) begin
      bad++;
      $display("FAIL %s_data dut%0d: got %h want %h", tag, d, sb_out_a[d], want);
    end
    total++;
    if (in_ready_a[d] !== 1'b0) begin
      bad++;
      $display("FAIL %s_stall_ready dut%0d: in_ready=%b want 0", tag, d, in_ready_a[d]);
    end
    $display("txn %s dut%0d inv=%b in=%h out=%h lat=%0d", tag, d, inv, din, sb_out_a[d], cyc);
    out_ready_a[d] = 1'b1;
    tick();
    out_ready_a[d] = 1'b0;
    total++;
    if (out_valid_a[d] !== 1'b0) begin
      bad++;
      $display("FAIL %s_drain dut%0d: out_valid=%b want 0", tag, d, out_valid_a[d]);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      in_valid_a[d]  = 1'b0;
      out_ready_a[d] = 1'b0;
      sb_in_a[d]     = '0;
      sb_inv_a[d]    = 1'b0;
    end
    tick();
    tick();
    for (int d = 0; d < 3; d++) begin
      total++;
      if (in_ready_a[d] !== 1'b1 || out_valid_a[d] !== 1'b0 || sb_out_a[d] !== 128'h0) begin
        bad++;
        $display("FAIL reset dut%0d: in_ready=%b out_valid=%b sb_out=%h want 1 0 0",
                 d, in_ready_a[d], out_valid_a[d], sb_out_a[d]);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_fips();
    run_one(0, 128'h193de3bea0f4e22b9ac68d2ae9f84808, 1'b0,
            128'hd42711aee0bf98f1b8b45de51e415230, "fips_fwd");
    run_one(0, 128'hd42711aee0bf98f1b8b45de51e415230, 1'b1,
            128'h193de3bea0f4e22b9ac68d2ae9f84808, "fips_inv");
  endtask

  task automatic test_boundary();
    logic [7:0] pat, res;
    for (int d = 0; d < 3; d++) begin
      for (int p = 0; p < 3; p++) begin
        case (p)
          0:       begin pat = 8'h00; res = 8'h63; end
          1:       begin pat = 8'hff; res = 8'h16; end
          default: begin pat = 8'h53; res = 8'hed; end
        endcase
        run_one(d, {16{pat}}, 1'b0, {16{res}}, "boundary");
      end
      run_one(d, {16{8'h16}}, 1'b1, {16{8'hff}}, "boundary_inv");
    end
  endtask

  task automatic test_random();
    logic [127:0] din;
    logic         inv;
    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < 4; n++) begin
        din = rnd128();
        inv = 1'($urandom_range(0, 1));
        run_one(d, din, inv, ref_sub(din, inv), "random");
      end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] x1, x2, w1;
    int cyc;
    x1 = rnd128();
    x2 = rnd128();
    w1 = ref_sub(x1, 1'b0);
    in_valid_a[0] = 1'b1;
    sb_in_a[0]    = x1;
    sb_inv_a[0]   = 1'b0;
    tick();
    in_valid_a[0] = 1'b1;
    sb_in_a[0]    = x2;
    sb_inv_a[0]   = 1'b1;
    cyc = 0;
    while (out_valid_a[0] !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      total++;
      if (out_valid_a[0] !== 1'b1 || sb_out_a[0] !== w1 || in_ready_a[0] !== 1'b0) begin
        bad++;
        $display("FAIL backpressure_hold cycle %0d: out_valid=%b in_ready=%b sb_out=%h want 1 0 %h",
                 i, out_valid_a[0], in_ready_a[0], sb_out_a[0], w1);
      end
    end
    out_ready_a[0] = 1'b1;
    #1;
    total++;
    if (in_ready_a[0] !== 1'b1) begin
      bad++;
      $display("FAIL backpressure_ready_comb: in_ready=%b want 1", in_ready_a[0]);
    end
    $display("txn backpressure_out dut0 out=%h", sb_out_a[0]);
    tick();
    out_ready_a[0] = 1'b0;
    in_valid_a[0]  = 1'b0;
    sb_inv_a[0]    = 1'b0;
    total++;
    if (out_valid_a[0] !== 1'b0) begin
      bad++;
      $display("FAIL backpressure_handoff: out_valid=%b want 0", out_valid_a[0]);
    end
    cyc = 0;
    while (out_valid_a[0] !== 1'b1 && cyc < 20) begin
      tick();
      cyc++;
    end
    total++;
    if (cyc != k_of(0) || sb_out_a[0] !== ref_sub(x2, 1'b1)) begin
      bad++;
      $display("FAIL backpressure_next: lat=%0d out=%h want lat=%0d out=%h",
               cyc, sb_out_a[0], k_of(0), ref_sub(x2, 1'b1));
    end
    $display("txn backpressure_next dut0 in=%h out=%h lat=%0d", x2, sb_out_a[0], cyc);
    out_ready_a[0] = 1'b1;
    tick();
    out_ready_a[0] = 1'b0;
  endtask

  task automatic test_streaming();
    logic [127:0] exp_q[$];
    logic [127:0] want;
    logic acc, del;
    int sent = 0, got = 0, cyc = 0, last = 0;
    in_valid_a[0]  = 1'b1;
    sb_in_a[0]     = rnd128();
    sb_inv_a[0]    = 1'($urandom_range(0, 1));
    out_ready_a[0] = 1'b1;
    while (got < 8 && cyc < 200) begin
      acc = in_valid_a[0] & in_ready_a[0];
      del = out_valid_a[0] & out_ready_a[0];
      if (acc) exp_q.push_back(ref_sub(sb_in_a[0], sb_inv_a[0]));
      if (del) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 128'hx;
        total++;
        if (sb_out_a[0] !== want) begin
          bad++;
          $display("FAIL stream_data #%0d: got %h want %h", got, sb_out_a[0], want);
        end
        if (got > 0) begin
          total++;
          if (cyc - last != k_of(0) + 1) begin
            bad++;
            $display("FAIL stream_spacing #%0d: got %0d cycles want %0d", got, cyc - last, k_of(0) + 1);
          end
        end
        $display("txn stream dut0 #%0d out=%h cycle=%0d", got, sb_out_a[0], cyc);
        last = cyc;
        got++;
      end
      tick();
      cyc++;
      if (acc) begin
        sent++;
        if (sent < 8) begin
          sb_in_a[0]  = rnd128();
          sb_inv_a[0] = 1'($urandom_range(0, 1));
        end else begin
          in_valid_a[0] = 1'b0;
        end
      end
    end
    out_ready_a[0] = 1'b0;
    total++;
    if (got != 8) begin
      bad++;
      $display("FAIL stream_count: got %0d results want 8", got);
    end
  endtask

  task automatic test_reset_busy();
    logic [127:0] din;
    in_valid_a[0] = 1'b1;
    sb_in_a[0]    = rnd128();
    sb_inv_a[0]   = 1'b0;
    tick();
    in_valid_a[0] = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      total++;
      if (out_valid_a[0] !== 1'b0 || sb_out_a[0] !== 128'h0 || in_ready_a[0] !== 1'b1) begin
        bad++;
        $display("FAIL reset_busy_%0d: out_valid=%b sb_out=%h in_ready=%b want 0 0 1",
                 i, out_valid_a[0], sb_out_a[0], in_ready_a[0]);
      end
      in_valid_a[0] = 1'b1;
      tick();
    end
    in_valid_a[0] = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < k_of(0) + 2; i++) begin
      tick();
      total++;
      if (out_valid_a[0] !== 1'b0 || in_ready_a[0] !== 1'b1) begin
        bad++;
        $display("FAIL reset_busy_stale cycle %0d: out_valid=%b in_ready=%b want 0 1",
                 i, out_valid_a[0], in_ready_a[0]);
      end
    end
    din = rnd128();
    run_one(0, din, 1'b1, ref_sub(din, 1'b1), "after_reset");
  endtask

  initial begin
    build_tables();
    test_reset();
    test_fips();
    test_boundary();
    test_random();
    test_backpressure();
    test_streaming();
    test_reset_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, total=%0d", total);
    $fatal(1, "timeout");
  end

endmodule
